i2c_basic: RTL and testbench



---
 rtl/i2c_basic_pkg.sv | 23 ++
 rtl/i2c_quarter_tick.sv | 29 ++
 rtl/i2c_basic.sv | 115 +++++++++++
 tb/tb_i2c_basic.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/i2c_basic_pkg.sv
// Shared state encoding and the per-quarter pin pattern table for the write-only I2C master.
package i2c_basic_pkg;

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK, DATA, STOP} state_t;

  localparam int QUARTERS_PER_BIT = 4;
  localparam int BITS_PER_BYTE    = 8;

  // Pin pattern {scl, sda, oe_n} for a given state/quarter; b is the bit on the wire in ADDR/DATA.
  function automatic logic [2:0] drive(input state_t st, input logic [1:0] q, input logic b);
    logic [2:0] o;
    o = 3'b111;
    case (st)
      START:      o = (q == 2'd0) ? 3'b110 : (q == 2'd3) ? 3'b000 : 3'b100;
      ADDR, DATA: o = {q[1], b, 1'b0};
      ACK:        o = {q[1], 2'b11};
      STOP:       o = (q == 2'd0) ? 3'b000 : (q == 2'd1) ? 3'b100 : 3'b110;
      default:    o = 3'b111;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit prescaler: tick when the counter is all-ones, 2-bit quarter index advances on tick.
module i2c_quarter_tick #(
  parameter int CLK_DIV_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  output logic       o_tick,
  output logic [1:0] o_quarter
);
  localparam logic [CLK_DIV_BITS-1:0] ONE = {{(CLK_DIV_BITS-1){1'b0}}, 1'b1};

  logic [CLK_DIV_BITS-1:0] r_cnt;
  logic [1:0]              r_quarter;

  assign o_tick    = &r_cnt;
  assign o_quarter = r_quarter;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt     <= '0;
      r_quarter <= 2'd0;
    end else begin
      r_cnt <= r_cnt + ONE;
      if (o_tick) r_quarter <= r_quarter + 2'd1;
    end
  end

endmodule

// File: rtl/i2c_basic.sv
// Minimal write-only I2C master: START, address+W, 0-3 data bytes, STOP, then a done pulse.
module i2c_basic
  import i2c_basic_pkg::*;
#(
  parameter int CLK_DIV_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] addr,
  input  logic [1:0] num_wr_bytes,
  input  logic [7:0] wr_data0,
  input  logic [7:0] wr_data1,
  input  logic [7:0] wr_data2,
  input  logic       start,
  output logic       done,
  output logic       sclk,
  output logic       sdata_out,
  output logic       sdata_oe_n
);
  state_t          r_state;
  logic [2:0]      r_out;        // {scl, sda, oe_n}
  logic            r_done;
  logic [7:0]      r_shift;
  logic [3:0][7:0] r_data;
  logic [1:0]      r_num;
  logic [2:0]      r_bit_cnt;
  logic [1:0]      r_bytes_sent;
  logic            w_tick;
  logic [1:0]      w_quarter;

  // Prescaler is held cleared while idle so every transaction starts on a fresh quarter.
  i2c_quarter_tick #(.CLK_DIV_BITS(CLK_DIV_BITS)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (r_state == IDLE),
    .o_tick    (w_tick),
    .o_quarter (w_quarter)
  );

  assign sclk       = r_out[2];
  assign sdata_out  = r_out[1];
  assign sdata_oe_n = r_out[0];
  assign done       = r_done;

  // Outputs are loaded with the pattern of the quarter being entered, so pins change on the tick edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_out        <= 3'b111;
      r_done       <= 1'b0;
      r_shift      <= 8'h00;
      r_data       <= '0;
      r_num        <= 2'd0;
      r_bit_cnt    <= 3'd0;
      r_bytes_sent <= 2'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_shift      <= {addr, 1'b0};
          r_data       <= {8'h00, wr_data2, wr_data1, wr_data0};
          r_num        <= num_wr_bytes;
          r_bit_cnt    <= 3'd0;
          r_bytes_sent <= 2'd0;
          r_state      <= START;
          r_out        <= drive(START, 2'd0, 1'b0);
        end
        default: if (w_tick) begin
          if (w_quarter != 2'd3) begin
            r_out <= drive(r_state, w_quarter + 2'd1, r_shift[7]);
          end else begin
            case (r_state)
              START: begin
                r_state <= ADDR;
                r_out   <= drive(ADDR, 2'd0, r_shift[7]);
              end
              ADDR, DATA: begin
                if (r_bit_cnt == 3'd7) begin
                  r_state <= ACK;
                  r_out   <= drive(ACK, 2'd0, 1'b1);
                end else begin
                  r_shift   <= {r_shift[6:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  r_out     <= drive(r_state, 2'd0, r_shift[6]);
                end
              end
              ACK: begin
                if (r_bytes_sent < r_num) begin
                  r_state      <= DATA;
                  r_shift      <= r_data[r_bytes_sent];
                  r_bytes_sent <= r_bytes_sent + 2'd1;
                  r_bit_cnt    <= 3'd0;
                  r_out        <= drive(DATA, 2'd0, r_data[r_bytes_sent][7]);
                end else begin
                  r_state <= STOP;
                  r_out   <= drive(STOP, 2'd0, 1'b0);
                end
              end
              STOP: begin
                r_state <= IDLE;
                r_done  <= 1'b1;
                r_out   <= 3'b111;
              end
              default: begin
                r_state <= IDLE;
                r_out   <= 3'b111;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_basic.sv
// Bench: one slow instance for exact latency, one fast instance for random/busy/reset traffic.
module tb_i2c_basic;
  localparam int KA = 8;
  localparam int KB = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] addr = '0;
  logic [1:0] num = '0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       done_a, scl_a, sdo_a, oen_a;
  logic       done_b, scl_b, sdo_b, oen_b;

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;
  int t_acc = 0;
  int n_start = 0, n_stop = 0, n_done = 0;
  bit sel = 1'b0;
  logic [1:0] cap_q[$];
  logic [1:0] exp_q[$];
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  logic [6:0] cur_a;
  logic [1:0] cur_n;
  logic [7:0] cur_d[3];
  int         cur_k;

  logic m_scl, m_oen, m_sda, m_done;
  assign m_scl  = sel ? scl_b : scl_a;
  assign m_oen  = sel ? oen_b : oen_a;
  assign m_sda  = m_oen ? 1'b1 : (sel ? sdo_b : sdo_a);
  assign m_done = sel ? done_b : done_a;

  i2c_basic #(.CLK_DIV_BITS(KA)) u_a (
    .clk(clk), .reset(reset), .addr(addr), .num_wr_bytes(num),
    .wr_data0(d0), .wr_data1(d1), .wr_data2(d2), .start(start_a),
    .done(done_a), .sclk(scl_a), .sdata_out(sdo_a), .sdata_oe_n(oen_a)
  );

  i2c_basic #(.CLK_DIV_BITS(KB)) u_b (
    .clk(clk), .reset(reset), .addr(addr), .num_wr_bytes(num),
    .wr_data0(d0), .wr_data1(d1), .wr_data2(d2), .start(start_b),
    .done(done_b), .sclk(scl_b), .sdata_out(sdo_b), .sdata_oe_n(oen_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now++;

  // Wire-level monitor: slots sampled on SCL rise; any SDA change while SCL stays high is START/STOP.
  always @(negedge clk) begin
    if (!prev_scl && m_scl) cap_q.push_back({m_oen, m_sda});
    if (prev_scl && m_scl && (m_sda !== prev_sda)) begin
      if (m_sda) n_stop++;
      else       n_start++;
    end
    if (m_done) n_done++;
    prev_scl = m_scl;
    prev_sda = m_sda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input bit b, input logic [6:0] a, input logic [1:0] n,
                    input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    @(negedge clk);
    sel = b;
    addr = a; num = n; d0 = x0; d1 = x1; d2 = x2;
    cur_a = a; cur_n = n; cur_d[0] = x0; cur_d[1] = x1; cur_d[2] = x2;
    cur_k = b ? KB : KA;
    cap_q.delete();
    n_start = 0; n_stop = 0; n_done = 0;
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    t_acc = cyc_now;
  endtask

  task automatic finish_txn(input string tag);
    int lat;
    logic [7:0] by[4];
    lat = (8 + 36 * (int'(cur_n) + 1)) << cur_k;
    while (!m_done && (cyc_now - t_acc) < lat + 50) @(negedge clk);
    chk($sformatf("%s.latency", tag), cyc_now - t_acc, lat);
    repeat (4) @(negedge clk);
    chk($sformatf("%s.done_cnt", tag), n_done, 1);
    chk($sformatf("%s.start_cnt", tag), n_start, 1);
    chk($sformatf("%s.stop_cnt", tag), n_stop, 1);
    chk($sformatf("%s.idle", tag), {m_scl, m_sda, m_oen, m_done}, 4'b1110);
    by[0] = {cur_a, 1'b0}; by[1] = cur_d[0]; by[2] = cur_d[1]; by[3] = cur_d[2];
    exp_q.delete();
    for (int k = 0; k <= int'(cur_n); k++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, by[k][i]});
      exp_q.push_back(2'b11);
    end
    exp_q.push_back(2'b00);
    chk($sformatf("%s.slots", tag), cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s.slot%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  initial begin
    logic [6:0] ra;
    logic [1:0] rn;
    logic [7:0] r0, r1, r2;

    // Reset held with start asserted: both instances must stay idle.
    start_a = 1'b1; start_b = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("reset.a", {scl_a, sdo_a, oen_a, done_a}, 4'b1110);
      chk("reset.b", {scl_b, sdo_b, oen_b, done_b}, 4'b1110);
    end
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset.a", {scl_a, sdo_a, oen_a, done_a}, 4'b1110);
    chk("post_reset.b", {scl_b, sdo_b, oen_b, done_b}, 4'b1110);
    chk("post_reset.done", n_done, 0);

    go(1'b0, 7'h41, 2'd3, 8'hFF, 8'hF1, 8'h7E);
    finish_txn("three_byte");
    go(1'b0, 7'h7F, 2'd0, 8'h00, 8'h00, 8'h00);
    finish_txn("addr_only");

    // Busy: new start and changed inputs mid-transaction must not disturb the byte stream.
    go(1'b1, 7'h2A, 2'd2, 8'hA5, 8'h3C, 8'hC3);
    repeat (60) @(negedge clk);
    addr = 7'h55; d0 = 8'h00; d1 = 8'hFF; d2 = 8'h12; num = 2'd3;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    finish_txn("busy");

    for (int t = 0; t < 8; t++) begin
      ra = 7'($urandom_range(0, 127));
      rn = 2'($urandom_range(0, 3));
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      go(1'b1, ra, rn, r0, r1, r2);
      finish_txn($sformatf("rand%0d", t));
    end

    // Reset during the first data byte: idle on the next cycle, no done afterwards.
    go(1'b1, 7'h33, 2'd2, 8'h0F, 8'hF0, 8'h99);
    repeat ((4 + 36 + 12) << KB) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.idle", {scl_b, sdo_b, oen_b, done_b}, 4'b1110);
    reset = 1'b0;
    repeat (600) @(negedge clk);
    chk("midreset.no_done", n_done, 0);
    chk("midreset.still_idle", {scl_b, sdo_b, oen_b, done_b}, 4'b1110);
    ra = 7'($urandom_range(0, 127));
    r0 = 8'($urandom);
    go(1'b1, ra, 2'd1, r0, 8'h5A, 8'hA5);
    finish_txn("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
